// File: rtl/sw_data_processor.sv
// Upstream feeder for the Smith-Waterman PE-array controller: buffers S and T from the host,
// presents one S symbol and one {t,v,f} ring entry per beat, and recirculates write-backs.
module sw_data_processor #(
  parameter int S_DEPTH = 256,
  parameter int T_DEPTH = 256,
  parameter int VEF_BIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_in_valid,
  input  logic [1:0]         i_in_data,
  input  logic               i_in_last,
  output logic               o_in_ready,
  input  logic               i_done,
  output logic               o_data_valid,
  input  logic               i_update_s,
  output logic [1:0]         o_s,
  output logic               o_s_last,
  input  logic               i_update_t,
  output logic [1:0]         o_t,
  output logic [VEF_BIT-1:0] o_v,
  output logic [VEF_BIT-1:0] o_f,
  output logic               o_t_last,
  input  logic               i_wb_valid,
  input  logic [1:0]         i_wb_t,
  input  logic [VEF_BIT-1:0] i_wb_v,
  input  logic [VEF_BIT-1:0] i_wb_f,
  output logic               o_err
);

  localparam int SAW = $clog2(S_DEPTH);
  localparam int TAW = $clog2(T_DEPTH);
  localparam int EW  = 2 + 2 * VEF_BIT;

  localparam logic [SAW:0]   S_FULL  = (SAW + 1)'(S_DEPTH);
  localparam logic [SAW:0]   S_ONE   = (SAW + 1)'(1);
  localparam logic [SAW-1:0] SP_ONE  = SAW'(1);
  localparam logic [TAW:0]   T_FULL  = (TAW + 1)'(T_DEPTH);
  localparam logic [TAW:0]   T_ONE   = (TAW + 1)'(1);
  localparam logic [TAW-1:0] TP_ONE  = TAW'(1);

  typedef enum logic [1:0] {IDLE, LOAD_S, LOAD_T, RUN} state_t;

  state_t state, state_nxt;

  logic [SAW:0]   s_len;
  logic [SAW-1:0] s_ptr;
  logic [TAW:0]   t_len;
  logic [TAW:0]   count;
  logic [TAW-1:0] rd_ptr;
  logic [TAW-1:0] wr_ptr;
  logic [TAW-1:0] pass_idx;
  logic           err;

  logic [1:0]    s_mem [S_DEPTH];
  logic [EW-1:0] ring  [T_DEPTH];

  logic          start_job;
  logic          load_s_acc, load_s_ovf;
  logic          load_t_acc, load_t_ovf;
  logic          wb_req, wb_acc, wb_ovf;
  logic          pop, s_adv;
  logic          s_last, t_last;
  logic          ring_we;
  logic [EW-1:0] ring_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_in_ready   = 1'b0;
    o_data_valid = 1'b0;
    case (state)
      IDLE:   if (i_start) state_nxt = LOAD_S;
      LOAD_S: begin
        o_in_ready = 1'b1;
        if (i_in_valid && i_in_last) state_nxt = LOAD_T;
      end
      LOAD_T: begin
        o_in_ready = 1'b1;
        if (i_in_valid && i_in_last) state_nxt = RUN;
      end
      RUN: begin
        o_data_valid = (count != '0);
        if (i_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lengths are one bit wider than pointers so an empty buffer never matches "last".
  assign s_last = ({1'b0, s_ptr} == (s_len - S_ONE));
  assign t_last = ({1'b0, pass_idx} == (t_len - T_ONE));

  assign start_job  = (state == IDLE) && i_start;
  assign load_s_acc = (state == LOAD_S) && i_in_valid && (s_len != S_FULL);
  assign load_s_ovf = (state == LOAD_S) && i_in_valid && (s_len == S_FULL);
  assign load_t_acc = (state == LOAD_T) && i_in_valid && (t_len != T_FULL);
  assign load_t_ovf = (state == LOAD_T) && i_in_valid && (t_len == T_FULL);

  assign pop    = o_data_valid && i_update_t;
  assign s_adv  = o_data_valid && i_update_s && !s_last;
  assign wb_req = (state == RUN) && i_wb_valid;
  // A full ring still accepts a write-back when the head is popped in the same cycle.
  assign wb_acc = wb_req && ((count != T_FULL) || pop);
  assign wb_ovf = wb_req && !wb_acc;

  assign ring_we    = load_t_acc || wb_acc;
  assign ring_wdata = load_t_acc ? {i_in_data, {(2 * VEF_BIT){1'b0}}}
                                 : {i_wb_t, i_wb_v, i_wb_f};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_len    <= '0;
      s_ptr    <= '0;
      t_len    <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      pass_idx <= '0;
      err      <= 1'b0;
    end else if (start_job) begin
      s_len    <= '0;
      s_ptr    <= '0;
      t_len    <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      pass_idx <= '0;
      err      <= 1'b0;
    end else begin
      if (load_s_acc) s_len <= s_len + S_ONE;
      if (load_t_acc) t_len <= t_len + T_ONE;
      if (s_adv)      s_ptr <= s_ptr + SP_ONE;
      if (pop) begin
        rd_ptr   <= rd_ptr + TP_ONE;
        pass_idx <= t_last ? '0 : pass_idx + TP_ONE;
      end
      if (ring_we) wr_ptr <= wr_ptr + TP_ONE;
      case ({ring_we, pop})
        2'b10:   count <= count + T_ONE;
        2'b01:   count <= count - T_ONE;
        default: count <= count;
      endcase
      if (load_s_ovf || load_t_ovf || wb_ovf) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < S_DEPTH; i++) s_mem[i] <= '0;
    end else if (load_s_acc) begin
      s_mem[s_len[SAW-1:0]] <= i_in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < T_DEPTH; i++) ring[i] <= '0;
    end else if (ring_we) begin
      ring[wr_ptr] <= ring_wdata;
    end
  end

  assign o_s              = s_mem[s_ptr];
  assign o_s_last         = s_last;
  assign {o_t, o_v, o_f}  = ring[rd_ptr];
  assign o_t_last         = t_last;
  assign o_err            = err;

endmodule

// File: doc/sw_data_processor.md
Name: sw_data_processor

Overview:
- Upstream feeder for the PE-array controller in the Smith-Waterman accelerator.
- Loads the query sequence S and the database sequence T from the host stream into on-chip register buffers.
- During a run, presents one S symbol and one {t,v,f} column entry per beat.
- Recirculates the {t,v,f} values written back by the controller after each pass through a ring buffer, so the next S chunk sees the previous pass's boundary column.

Parameters:
- S_DEPTH, 256, maximum S length (symbols); power of two.
- T_DEPTH, 256, maximum T length and ring-buffer entries; power of two.
- VEF_BIT, 16, width of v/f scores (two's complement).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- i_start  in  1  pulse: begin loading a new job (honoured only in IDLE)
- i_in_valid  in  1  host symbol valid
- i_in_data  in  2  host symbol (A/C/G/T code)
- i_in_last  in  1  last symbol of current sequence (S, then T)
- o_in_ready  out  1  high in LOAD_S/LOAD_T
- i_done  in  1  pulse from controller: job finished, return to IDLE
- o_data_valid  out  1  current beat presented is valid
- i_update_s  in  1  advance S on a valid beat
- o_s  out  2  current S symbol
- o_s_last  out  1  current S symbol is last
- i_update_t  in  1  pop T entry on a valid beat
- o_t  out  2  head T symbol
- o_v  out  VEF_BIT  head v
- o_f  out  VEF_BIT  head f
- o_t_last  out  1  head entry is last of current pass
- i_wb_valid  in  1  write-back entry valid
- i_wb_t  in  2  write-back t
- i_wb_v  in  VEF_BIT  write-back v
- i_wb_f  in  VEF_BIT  write-back f
- o_err  out  1  sticky: length overflow or ring overflow

Behaviour:
- States: IDLE -> LOAD_S -> LOAD_T -> RUN -> IDLE.
  - IDLE->LOAD_S on i_start. Clears s_len, t_len, pointers, count and o_err.
  - LOAD_S: each i_in_valid writes s_mem[s_len] and increments s_len. i_in_last moves to LOAD_T.
  - LOAD_T: each i_in_valid writes {data,0,0} at wr_ptr, then increments wr_ptr, count and t_len. i_in_last moves to RUN.
  - RUN->IDLE on i_done. i_start is ignored outside IDLE.
- Load overflow: a symbol arriving when the length already equals the depth is dropped and o_err is set. i_in_last still advances the state.
- o_data_valid = (state==RUN) & (count!=0). This is a combinational function of registered state only; there is no input-to-output path.
- Presented outputs are zero latency from registered pointers:
  - o_s = s_mem[s_ptr]; o_s_last = (s_ptr==s_len-1).
  - o_t/o_v/o_f = ring[rd_ptr]; o_t_last = (pass_idx==t_len-1).
- Beat = o_data_valid in a cycle. On a beat:
  - If i_update_s: s_ptr increments, saturating at s_len-1.
  - If i_update_t: rd_ptr increments mod T_DEPTH, count decrements, and pass_idx increments, wrapping to 0 after t_len-1.
- Update inputs are ignored when o_data_valid is low.
- Write-back: i_wb_valid in RUN writes {t,v,f} at wr_ptr and increments wr_ptr mod T_DEPTH and count.
  - Ignored outside RUN.
  - If count==T_DEPTH and no pop occurs in the same cycle, the write is dropped and o_err is set.
- Simultaneous pop and write-back: count is unchanged and both pointers advance. A write to the entry being popped in the same cycle is legal (read-before-write).
- Empty ring in RUN drops o_data_valid low; the controller stalls until the write-back arrives.
- Pointer arithmetic: rd_ptr/wr_ptr are log2(T_DEPTH) bits with natural wrap. count is log2(T_DEPTH)+1 bits.
- Reset values:
  - State IDLE; all pointers, lengths, count and pass_idx are 0.
  - o_in_ready=0, o_data_valid=0, o_err=0.
  - o_s/o_t/o_v/o_f read entry 0 of cleared memories (all 0); o_s_last and o_t_last are 0.
- Reset asserted mid-run aborts immediately to IDLE with the reset values above. Memory contents need not be cleared, but outputs must read 0 because the memories are cleared on reset.
- Zero-length sequences are not supported: a lone i_in_last with i_in_valid loads one symbol.

Test Plan:
- Load S=ACGT (0,1,2,3) and T=GGA (2,2,0), then hold i_update_t=1 -> o_t sequence is 2,2,0 with o_v=o_f=0; o_t_last is high on the third beat; o_data_valid then drops to 0.
- After pass 1, write back (2,5,3), (2,7,1), (0,4,0) -> the next three beats present those entries in order; o_t_last is high on (0,4,0).
- Present 4 beats with i_update_s=1 and S length 4 -> o_s = 0,1,2,3; o_s_last is high on the 4th beat and o_s stays 3 on further beats.
- With count=1, pop and write back in the same cycle -> count stays 1, o_data_valid stays 1, and the new entry is presented next cycle.
- T_DEPTH=4: load 4 T symbols, then write back with no pop -> o_err=1 and the ring contents are unchanged. Loading a 5th S symbol with S_DEPTH=4 -> dropped, o_err=1.
- Assert rst_n=0 in RUN with count=3 -> o_data_valid=0, o_err=0, state IDLE. i_in_valid while in IDLE is ignored.
